switch_debouncer: RTL

- Conditions raw, asynchronous slide-switch inputs before they reach the Avalon switch PIO's in_port.
- Per bit: a synchronizer chain, then a stability counter. Only levels held for CNT_MAX consecutive clk cycles reach the output.
- Also emits one-cycle rise and fall strobes for interrupt or event logic.
- Sits between the FPGA switch pins and the PIO input port, in the PIO's clk domain.

---
 rtl/switch_debouncer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/switch_debouncer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// switch_debouncer
//   Synchronizes and debounces raw slide-switch inputs, with rise/fall strobes.
//   Revision: 1.0
// ---------------------------------------------------------------------------
module switch_debouncer #(
  parameter int                 WIDTH       = 4,
  parameter int                 CNT_MAX     = 50000,
  parameter int                 CNT_W       = 16,
  parameter int                 SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0]   RESET_VAL   = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_debounced,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_changed
);

  typedef enum logic [0:0] {
    ST_STABLE   = 1'b0,
    ST_COUNTING = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(CNT_MAX - 1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  logic [WIDTH-1:0] r_deb;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic             r_changed;
  logic [WIDTH-1:0] w_upd;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic [SYNC_STAGES-1:0] r_sync;
      logic                   w_s;
      state_t                 r_state;
      state_t                 w_state_nxt;
      logic [CNT_W-1:0]       r_cnt;
      logic [CNT_W-1:0]       w_cnt_nxt;
      logic                   w_update;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_sync <= {SYNC_STAGES{RESET_VAL[i]}};
        end else begin
          r_sync <= {r_sync[SYNC_STAGES-2:0], sw_raw[i]};
        end
      end

      assign w_s = r_sync[SYNC_STAGES-1];

      always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_update    = 1'b0;
        case (r_state)
          ST_STABLE: begin
            w_cnt_nxt = '0;
            if (w_s != r_deb[i]) begin
              // A single required cycle means the first mismatch already qualifies.
              if (CNT_MAX == 1) begin
                w_update = 1'b1;
              end else begin
                w_state_nxt = ST_COUNTING;
                w_cnt_nxt   = c_cnt_one;
              end
            end
          end
          ST_COUNTING: begin
            if (w_s == r_deb[i]) begin
              w_state_nxt = ST_STABLE;
              w_cnt_nxt   = '0;
            end else if (r_cnt == c_cnt_last) begin
              w_update    = 1'b1;
              w_state_nxt = ST_STABLE;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = r_cnt + c_cnt_one;
            end
          end
          default: begin
            w_state_nxt = ST_STABLE;
            w_cnt_nxt   = '0;
          end
        endcase
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_state <= ST_STABLE;
          r_cnt   <= '0;
        end else begin
          r_state <= w_state_nxt;
          r_cnt   <= w_cnt_nxt;
        end
      end

      assign w_upd[i] = w_update;
    end
  endgenerate

  // An update always moves the bit to the opposite level, so XOR applies it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_deb     <= RESET_VAL;
      r_rise    <= '0;
      r_fall    <= '0;
      r_changed <= 1'b0;
    end else begin
      r_deb     <= r_deb ^ w_upd;
      r_rise    <= w_upd & ~r_deb;
      r_fall    <= w_upd & r_deb;
      r_changed <= |w_upd;
    end
  end

  assign sw_debounced = r_deb;
  assign sw_rise      = r_rise;
  assign sw_fall      = r_fall;
  assign sw_changed   = r_changed;

endmodule
`default_nettype wire
